// File: rtl/cc_sidecomparator_qualified.sv
// Dwell-qualified left/right boundary comparator for one player row: level, pulse, saturating hit counts.
// Optional sticky hit flags are built only when SIDECOMPARATOR_STICKY_EN is defined.

module cc_sidecomparator_side #(
  parameter int DW    = 8,
  parameter int POS   = 7,
  parameter int DWELL = 1,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          resetLow,
  input  logic          enable,
  input  logic          clear,
  input  logic [DW-1:0] dataBus,
  output logic          level,
  output logic          pulse,
  output logic [CW-1:0] count,
  output logic          sticky,
  output logic [1:0]    stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HIT  = 2'd2
  } sideState_t;

  localparam int            DWW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
  localparam logic [DW-1:0]  MATCH      = DW'(1) << POS;
  localparam logic [CW-1:0]  COUNT_MAX  = '1;
  localparam bit             SINGLE     = (DWELL == 1);

  sideState_t     state;
  logic [DWW-1:0] dwell;
  logic           matchEn;
  logic           hitNow;

  // Exact compare: multi-hot and all-zero buses never match.
  assign matchEn = enable && (dataBus == MATCH);

  // True on the edge where qualification completes and the pulse is launched.
  assign hitNow = matchEn && (((state == IDLE) && SINGLE) ||
                              ((state == QUAL) && (dwell == DWELL_LAST)));

  assign stateDbg = state;

  always_ff @(posedge clk) begin
    if (!resetLow) begin
      state <= IDLE;
      dwell <= '0;
      level <= 1'b1;
      pulse <= 1'b1;
    end else begin
      pulse <= 1'b1;
      case (state)
        IDLE: begin
          level <= 1'b1;
          if (matchEn) begin
            if (SINGLE) begin
              state <= HIT;
              level <= 1'b0;
              pulse <= 1'b0;
              dwell <= '0;
            end else begin
              state <= QUAL;
              dwell <= DWW'(1);
            end
          end else begin
            dwell <= '0;
          end
        end
        QUAL: begin
          level <= 1'b1;
          if (matchEn) begin
            if (dwell == DWELL_LAST) begin
              state <= HIT;
              level <= 1'b0;
              pulse <= 1'b0;
              dwell <= '0;
            end else begin
              dwell <= dwell + DWW'(1);
            end
          end else begin
            state <= IDLE;
            dwell <= '0;
          end
        end
        HIT: begin
          if (!matchEn) begin
            state <= IDLE;
            level <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dwell <= '0;
          level <= 1'b1;
        end
      endcase
    end
  end

  // Clear has priority over a same-cycle hit; the count never wraps.
  always_ff @(posedge clk) begin
    if (!resetLow) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (hitNow && (count != COUNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

`ifdef SIDECOMPARATOR_STICKY_EN
  always_ff @(posedge clk) begin
    if (!resetLow) begin
      sticky <= 1'b1;
    end else if (clear) begin
      sticky <= 1'b1;
    end else if (hitNow) begin
      sticky <= 1'b0;
    end
  end
`else
  assign sticky = 1'b1;
`endif

endmodule

module cc_sidecomparator_qualified #(
  parameter int SIDECOMPARATOR_DATAWIDTH  = 8,
  parameter int SIDECOMPARATOR_LEFT_POS   = 7,
  parameter int SIDECOMPARATOR_RIGHT_POS  = 4,
  parameter int SIDECOMPARATOR_DWELL      = 1,
  parameter int SIDECOMPARATOR_COUNTWIDTH = 4
) (
  input  logic                                 CC_SIDECOMPARATOR_CLOCK_50,
  input  logic                                 CC_SIDECOMPARATOR_RESET_InLow,
  input  logic                                 CC_SIDECOMPARATOR_enable_InHigh,
  input  logic                                 CC_SIDECOMPARATOR_clear_InHigh,
  input  logic [SIDECOMPARATOR_DATAWIDTH-1:0]  CC_SIDECOMPARATOR_data_InBUS,
  output logic                                 CC_SIDECOMPARATOR_izquierda_OutLow,
  output logic                                 CC_SIDECOMPARATOR_derecha_OutLow,
  output logic                                 CC_SIDECOMPARATOR_izquierdaPulse_OutLow,
  output logic                                 CC_SIDECOMPARATOR_derechaPulse_OutLow,
  output logic [SIDECOMPARATOR_COUNTWIDTH-1:0] CC_SIDECOMPARATOR_izquierdaCount_OutBUS,
  output logic [SIDECOMPARATOR_COUNTWIDTH-1:0] CC_SIDECOMPARATOR_derechaCount_OutBUS,
  output logic                                 CC_SIDECOMPARATOR_izquierdaSticky_OutLow,
  output logic                                 CC_SIDECOMPARATOR_derechaSticky_OutLow,
  output logic [3:0]                           CC_SIDECOMPARATOR_stateDbg_OutBUS
);

  logic [1:0] leftState;
  logic [1:0] rightState;

  // Debug view: [3:2] right FSM state, [1:0] left FSM state (0 IDLE, 1 QUAL, 2 HIT).
  assign CC_SIDECOMPARATOR_stateDbg_OutBUS = {rightState, leftState};

  cc_sidecomparator_side #(
    .DW    (SIDECOMPARATOR_DATAWIDTH),
    .POS   (SIDECOMPARATOR_LEFT_POS),
    .DWELL (SIDECOMPARATOR_DWELL),
    .CW    (SIDECOMPARATOR_COUNTWIDTH)
  ) leftSide (
    .clk      (CC_SIDECOMPARATOR_CLOCK_50),
    .resetLow (CC_SIDECOMPARATOR_RESET_InLow),
    .enable   (CC_SIDECOMPARATOR_enable_InHigh),
    .clear    (CC_SIDECOMPARATOR_clear_InHigh),
    .dataBus  (CC_SIDECOMPARATOR_data_InBUS),
    .level    (CC_SIDECOMPARATOR_izquierda_OutLow),
    .pulse    (CC_SIDECOMPARATOR_izquierdaPulse_OutLow),
    .count    (CC_SIDECOMPARATOR_izquierdaCount_OutBUS),
    .sticky   (CC_SIDECOMPARATOR_izquierdaSticky_OutLow),
    .stateDbg (leftState)
  );

  cc_sidecomparator_side #(
    .DW    (SIDECOMPARATOR_DATAWIDTH),
    .POS   (SIDECOMPARATOR_RIGHT_POS),
    .DWELL (SIDECOMPARATOR_DWELL),
    .CW    (SIDECOMPARATOR_COUNTWIDTH)
  ) rightSide (
    .clk      (CC_SIDECOMPARATOR_CLOCK_50),
    .resetLow (CC_SIDECOMPARATOR_RESET_InLow),
    .enable   (CC_SIDECOMPARATOR_enable_InHigh),
    .clear    (CC_SIDECOMPARATOR_clear_InHigh),
    .dataBus  (CC_SIDECOMPARATOR_data_InBUS),
    .level    (CC_SIDECOMPARATOR_derecha_OutLow),
    .pulse    (CC_SIDECOMPARATOR_derechaPulse_OutLow),
    .count    (CC_SIDECOMPARATOR_derechaCount_OutBUS),
    .sticky   (CC_SIDECOMPARATOR_derechaSticky_OutLow),
    .stateDbg (rightState)
  );

endmodule

// File: tb/tb_cc_sidecomparator_qualified.sv
// Directed bench for cc_sidecomparator_qualified: a DWELL=1 instance and a DWELL=3 instance on shared inputs.
// Sticky expectations follow SIDECOMPARATOR_STICKY_EN as compiled.

module tb_cc_sidecomparator_qualified;

`ifdef SIDECOMPARATOR_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic [7:0] bus;

  logic       a_izq, a_der, a_izq_p, a_der_p, a_izq_s, a_der_s;
  logic [3:0] a_izq_c, a_der_c, a_state;
  logic       b_izq, b_der, b_izq_p, b_der_p, b_izq_s, b_der_s;
  logic [3:0] b_izq_c, b_der_c, b_state;

  int checks = 0;
  int errors = 0;

  // Clock and reset defaults
  always #5 clk = ~clk;

  cc_sidecomparator_qualified dut (
    .CC_SIDECOMPARATOR_CLOCK_50               (clk),
    .CC_SIDECOMPARATOR_RESET_InLow            (rst_n),
    .CC_SIDECOMPARATOR_enable_InHigh          (enable),
    .CC_SIDECOMPARATOR_clear_InHigh           (clear),
    .CC_SIDECOMPARATOR_data_InBUS             (bus),
    .CC_SIDECOMPARATOR_izquierda_OutLow       (a_izq),
    .CC_SIDECOMPARATOR_derecha_OutLow         (a_der),
    .CC_SIDECOMPARATOR_izquierdaPulse_OutLow  (a_izq_p),
    .CC_SIDECOMPARATOR_derechaPulse_OutLow    (a_der_p),
    .CC_SIDECOMPARATOR_izquierdaCount_OutBUS  (a_izq_c),
    .CC_SIDECOMPARATOR_derechaCount_OutBUS    (a_der_c),
    .CC_SIDECOMPARATOR_izquierdaSticky_OutLow (a_izq_s),
    .CC_SIDECOMPARATOR_derechaSticky_OutLow   (a_der_s),
    .CC_SIDECOMPARATOR_stateDbg_OutBUS        (a_state)
  );

  cc_sidecomparator_qualified #(.SIDECOMPARATOR_DWELL(3)) dut_d3 (
    .CC_SIDECOMPARATOR_CLOCK_50               (clk),
    .CC_SIDECOMPARATOR_RESET_InLow            (rst_n),
    .CC_SIDECOMPARATOR_enable_InHigh          (enable),
    .CC_SIDECOMPARATOR_clear_InHigh           (clear),
    .CC_SIDECOMPARATOR_data_InBUS             (bus),
    .CC_SIDECOMPARATOR_izquierda_OutLow       (b_izq),
    .CC_SIDECOMPARATOR_derecha_OutLow         (b_der),
    .CC_SIDECOMPARATOR_izquierdaPulse_OutLow  (b_izq_p),
    .CC_SIDECOMPARATOR_derechaPulse_OutLow    (b_der_p),
    .CC_SIDECOMPARATOR_izquierdaCount_OutBUS  (b_izq_c),
    .CC_SIDECOMPARATOR_derechaCount_OutBUS    (b_der_c),
    .CC_SIDECOMPARATOR_izquierdaSticky_OutLow (b_izq_s),
    .CC_SIDECOMPARATOR_derechaSticky_OutLow   (b_der_s),
    .CC_SIDECOMPARATOR_stateDbg_OutBUS        (b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected sticky level for a side that has (latched=1) or has not latched since the last clear.
  function automatic logic exp_sticky(input logic latched);
    return (latched && STICKY_ON) ? 1'b0 : 1'b1;
  endfunction

  // Driver: apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic [7:0] b, input logic en, input logic clr);
    bus    = b;
    enable = en;
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    bus    = 8'b1000_0000;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    check("rst_izq", 32'(a_izq), 32'd1);
    check("rst_der", 32'(a_der), 32'd1);
    check("rst_izq_p", 32'(a_izq_p), 32'd1);
    check("rst_der_p", 32'(a_der_p), 32'd1);
    check("rst_izq_c", 32'(a_izq_c), 32'd0);
    check("rst_der_c", 32'(a_der_c), 32'd0);
    check("rst_sticky", 32'({a_izq_s, a_der_s}), 32'd3);
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_d3_izq", 32'(b_izq), 32'd1);

    // Left contact held 3 cycles
    rst_n = 1'b1;
    cyc(8'b1000_0000, 1'b1, 1'b0);
    check("l1_izq", 32'(a_izq), 32'd0);
    check("l1_izq_p", 32'(a_izq_p), 32'd0);
    check("l1_izq_c", 32'(a_izq_c), 32'd1);
    check("l1_der", 32'(a_der), 32'd1);
    check("l1_d3_izq", 32'(b_izq), 32'd1);
    cyc(8'b1000_0000, 1'b1, 1'b0);
    check("l2_izq", 32'(a_izq), 32'd0);
    check("l2_izq_p", 32'(a_izq_p), 32'd1);
    check("l2_d3_izq", 32'(b_izq), 32'd1);
    cyc(8'b1000_0000, 1'b1, 1'b0);
    check("l3_izq", 32'(a_izq), 32'd0);
    check("l3_izq_c", 32'(a_izq_c), 32'd1);
    check("l3_der_p", 32'(a_der_p), 32'd1);
    check("l3_d3_izq", 32'(b_izq), 32'd0);
    check("l3_d3_izq_p", 32'(b_izq_p), 32'd0);
    cyc(8'b0000_0000, 1'b1, 1'b0);
    check("l4_izq", 32'(a_izq), 32'd1);
    check("l4_izq_c", 32'(a_izq_c), 32'd1);
    check("l4_der_c", 32'(a_der_c), 32'd0);
    check("l4_izq_s", 32'(a_izq_s), 32'(exp_sticky(1'b1)));
    check("l4_der_s", 32'(a_der_s), 32'(exp_sticky(1'b0)));
    cyc(8'b0000_0000, 1'b1, 1'b1);
    check("clr_izq_c", 32'(a_izq_c), 32'd0);
    check("clr_izq_s", 32'(a_izq_s), 32'd1);
    check("clr_d3_izq_c", 32'(b_izq_c), 32'd0);

    // Right side with a one-cycle gap: DWELL=3 restarts qualification
    cyc(8'b0001_0000, 1'b1, 1'b0);
    check("r1_der", 32'(a_der), 32'd0);
    check("r1_d3_der", 32'(b_der), 32'd1);
    cyc(8'b0001_0000, 1'b1, 1'b0);
    check("r2_d3_der", 32'(b_der), 32'd1);
    check("r2_d3_state", 32'(b_state), 32'h4);
    cyc(8'b0000_0000, 1'b1, 1'b0);
    check("r3_d3_der", 32'(b_der), 32'd1);
    cyc(8'b0001_0000, 1'b1, 1'b0);
    check("r4_d3_der", 32'(b_der), 32'd1);
    cyc(8'b0001_0000, 1'b1, 1'b0);
    check("r5_d3_der", 32'(b_der), 32'd1);
    check("r5_d3_der_p", 32'(b_der_p), 32'd1);
    cyc(8'b0001_0000, 1'b1, 1'b0);
    check("r6_d3_der", 32'(b_der), 32'd0);
    check("r6_d3_der_p", 32'(b_der_p), 32'd0);
    check("r6_d3_der_c", 32'(b_der_c), 32'd1);
    check("r6_der_c", 32'(a_der_c), 32'd2);
    check("r6_der_p", 32'(a_der_p), 32'd1);
    cyc(8'b0001_0000, 1'b1, 1'b0);
    check("r7_d3_der_p", 32'(b_der_p), 32'd1);
    check("r7_d3_der_c", 32'(b_der_c), 32'd1);
    cyc(8'b0000_0000, 1'b1, 1'b0);
    check("r8_d3_der", 32'(b_der), 32'd1);

    // Multi-hot bus is a mismatch on both sides
    cyc(8'b1001_0000, 1'b1, 1'b0);
    cyc(8'b1001_0000, 1'b1, 1'b0);
    check("mh_levels", 32'({a_izq, a_der, a_izq_p, a_der_p}), 32'hF);
    check("mh_counts", 32'({a_izq_c, a_der_c}), 32'h02);
    check("mh_state", 32'(a_state), 32'd0);

    // Enable dropped mid-HIT
    cyc(8'b1000_0000, 1'b1, 1'b0);
    check("en1_izq", 32'(a_izq), 32'd0);
    cyc(8'b1000_0000, 1'b0, 1'b0);
    check("en0_izq", 32'(a_izq), 32'd1);
    check("en0_izq_c", 32'(a_izq_c), 32'd1);
    check("en0_izq_p", 32'(a_izq_p), 32'd1);
    cyc(8'b1000_0000, 1'b1, 1'b0);
    check("en2_izq_p", 32'(a_izq_p), 32'd0);
    check("en2_izq_c", 32'(a_izq_c), 32'd2);
    cyc(8'b0000_0000, 1'b1, 1'b1);
    check("sat_clr", 32'(a_izq_c), 32'd0);

    // Saturation: 17 separate single-cycle contacts
    for (int i = 0; i < 17; i++) begin
      cyc(8'b1000_0000, 1'b1, 1'b0);
      cyc(8'b0000_0000, 1'b1, 1'b0);
      if (i == 14) check("sat_15", 32'(a_izq_c), 32'd15);
    end
    check("sat_17", 32'(a_izq_c), 32'd15);
    check("sat_d3_izq_c", 32'(b_izq_c), 32'd0);
    check("sat_izq_s", 32'(a_izq_s), 32'(exp_sticky(1'b1)));
    cyc(8'b1000_0000, 1'b1, 1'b1);
    check("clrhit_izq_c", 32'(a_izq_c), 32'd0);
    check("clrhit_izq_p", 32'(a_izq_p), 32'd0);
    check("clrhit_izq", 32'(a_izq), 32'd0);
    check("clrhit_izq_s", 32'(a_izq_s), 32'd1);
    cyc(8'b0000_0000, 1'b1, 1'b0);
    check("end_izq", 32'(a_izq), 32'd1);
    check("end_der_s", 32'({a_der_s, b_der_s}), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
